// File: rtl/draw_pkg.sv
// Shared constants, colour values and FSM state encoding for the board
// region painter.
package draw_pkg;
    localparam int COLOUR_W     = 6;
    localparam int DEF_BOARD_W  = 10;
    localparam int DEF_BOARD_H  = 25;
    localparam int DEF_CELL_PX  = 4;
    localparam int DEF_X_ORIGIN = 59;
    localparam int DEF_Y_ORIGIN = 11;

    localparam logic [COLOUR_W-1:0] COLOUR_EMPTY = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } draw_state_t;
endpackage

// File: rtl/board_pixel_scan.sv
// Cell/pixel scan counters for the region painter: walks ox, oy, col, row in
// that order and registers the board RAM address of the cell being scanned.
module board_pixel_scan
    import draw_pkg::*;
#(
    parameter int BOARD_W  = DEF_BOARD_W,
    parameter int CELL_PX  = DEF_CELL_PX,
    parameter int X_ORIGIN = DEF_X_ORIGIN,
    parameter int Y_ORIGIN = DEF_Y_ORIGIN,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [5:0]        row_lo,
    input  logic [5:0]        row_hi,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        px_x,
    output logic [6:0]        px_y,
    output logic              px_border,
    output logic              last
);
    localparam int COL_W = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
    localparam int OFS_W = $clog2(CELL_PX);
    localparam logic [OFS_W-1:0] OFS_MAX = OFS_W'(CELL_PX - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(BOARD_W - 1);

    logic [5:0]       row, row_n;
    logic [COL_W-1:0] col, col_n;
    logic [OFS_W-1:0] ox, oy, ox_n, oy_n;

    assign last = (ox == OFS_MAX) && (oy == OFS_MAX) && (col == COL_MAX) && (row == row_hi);

    // CELL_PX is a power of two, so ox/oy wrap on their own; col needs an explicit wrap.
    always_comb begin
        row_n = row;
        col_n = col;
        ox_n  = ox;
        oy_n  = oy;
        if (load) begin
            row_n = row_lo;
            col_n = '0;
            ox_n  = '0;
            oy_n  = '0;
        end else if (advance && !last) begin
            ox_n = ox + 1'b1;
            if (ox == OFS_MAX) begin
                oy_n = oy + 1'b1;
                if (oy == OFS_MAX) begin
                    col_n = col + 1'b1;
                    if (col == COL_MAX) begin
                        col_n = '0;
                        row_n = row + 6'd1;
                    end
                end
            end
        end
    end

    // The address follows the next counter values so it changes on the same edge as the cell.
    always_ff @(posedge clk) begin
        if (reset) begin
            row      <= '0;
            col      <= '0;
            ox       <= '0;
            oy       <= '0;
            ram_addr <= '0;
        end else begin
            row      <= row_n;
            col      <= col_n;
            ox       <= ox_n;
            oy       <= oy_n;
            ram_addr <= ADDR_W'(row_n) * ADDR_W'(BOARD_W) + ADDR_W'(col_n);
        end
    end

    assign px_x      = 8'(X_ORIGIN) + (8'(col) << OFS_W) + 8'(ox);
    assign px_y      = 7'(Y_ORIGIN) + (7'(row) << OFS_W) + 7'(oy);
    assign px_border = (ox == '0) || (oy == '0) || (ox == OFS_MAX) || (oy == OFS_MAX);
endmodule

// File: rtl/draw_board_region.sv
// Paints a band of board rows onto the VGA adapter, one pixel per cycle,
// reading cell colours from board RAM with a configurable read latency.
module draw_board_region
    import draw_pkg::*;
#(
    parameter int BOARD_W     = DEF_BOARD_W,
    parameter int BOARD_H     = DEF_BOARD_H,
    parameter int CELL_PX     = DEF_CELL_PX,
    parameter int X_ORIGIN    = DEF_X_ORIGIN,
    parameter int Y_ORIGIN    = DEF_Y_ORIGIN,
    parameter int RAM_LATENCY = 1,
    parameter int COLOUR_W    = draw_pkg::COLOUR_W,
    parameter int ADDR_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [5:0]          row_lo,
    input  logic [5:0]          row_hi,
    input  logic                outline_en,
    input  logic [COLOUR_W-1:0] outline_colour,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [COLOUR_W-1:0] ram_Q,
    output logic [7:0]          X,
    output logic [6:0]          Y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    localparam logic [5:0] ROW_MAX = 6'(BOARD_H - 1);

    draw_state_t         state;
    logic [5:0]          row_hi_q;
    logic                outline_en_q;
    logic [COLOUR_W-1:0] outline_colour_q;
    logic [1:0]          drain_cnt;
    logic [5:0]          row_hi_clamped;
    logic                accept, advance, scan_last;
    logic [7:0]          sx;
    logic [6:0]          sy;
    logic                sborder;

    logic [7:0] x_p      [RAM_LATENCY];
    logic [6:0] y_p      [RAM_LATENCY];
    logic       border_p [RAM_LATENCY];
    logic       valid_p  [RAM_LATENCY];

    assign row_hi_clamped = (row_hi > ROW_MAX) ? ROW_MAX : row_hi;
    // busy stays high through the done cycle (state already IDLE), so gate on it too.
    assign accept  = (state == ST_IDLE) && start && !busy;
    assign advance = (state == ST_RUN);

    board_pixel_scan #(
        .BOARD_W (BOARD_W),
        .CELL_PX (CELL_PX),
        .X_ORIGIN(X_ORIGIN),
        .Y_ORIGIN(Y_ORIGIN),
        .ADDR_W  (ADDR_W)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .advance  (advance),
        .row_lo   (row_lo),
        .row_hi   (row_hi_q),
        .ram_addr (ram_addr),
        .px_x     (sx),
        .px_y     (sy),
        .px_border(sborder),
        .last     (scan_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            drain_cnt        <= '0;
            row_hi_q         <= '0;
            outline_en_q     <= 1'b0;
            outline_colour_q <= '0;
        end else begin
            done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        busy             <= 1'b1;
                        row_hi_q         <= row_hi_clamped;
                        outline_en_q     <= outline_en;
                        outline_colour_q <= outline_colour;
                        state            <= (row_lo > row_hi_clamped) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (scan_last) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 2'(RAM_LATENCY - 1)) state <= ST_DONE;
                    else drain_cnt <= drain_cnt + 2'd1;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Coordinates ride alongside the RAM read so they meet ram_Q in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                x_p[i]      <= '0;
                y_p[i]      <= '0;
                border_p[i] <= 1'b0;
                valid_p[i]  <= 1'b0;
            end
            X      <= '0;
            Y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            x_p[0]      <= sx;
            y_p[0]      <= sy;
            border_p[0] <= sborder;
            valid_p[0]  <= advance;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                x_p[i]      <= x_p[i-1];
                y_p[i]      <= y_p[i-1];
                border_p[i] <= border_p[i-1];
                valid_p[i]  <= valid_p[i-1];
            end
            X    <= x_p[RAM_LATENCY-1];
            Y    <= y_p[RAM_LATENCY-1];
            plot <= valid_p[RAM_LATENCY-1];
            if (outline_en_q && (ram_Q != COLOUR_EMPTY) && border_p[RAM_LATENCY-1])
                colour <= outline_colour_q;
            else
                colour <= ram_Q;
        end
    end
endmodule

// File: tb/tb_draw_board_region.sv
// Directed bench for draw_board_region: a default build (RAM latency 1) and a
// RAM latency 3 build, each checked pixel by pixel against a scan model.
module tb_draw_board_region;
    localparam int BW = 10;
    localparam int BH = 25;
    localparam int CP = 4;
    localparam int XO = 59;
    localparam int YO = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start0, start1;
    logic [5:0] row_lo, row_hi;
    logic       outline_en;
    logic [5:0] outline_colour;
    logic [7:0] ram_addr0, ram_addr1;
    logic [5:0] ram_q0, ram_q1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [5:0] c0, c1;
    logic       plot0, plot1, busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    draw_board_region u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .row_lo(row_lo), .row_hi(row_hi),
        .outline_en(outline_en), .outline_colour(outline_colour), .ram_addr(ram_addr0),
        .ram_Q(ram_q0), .X(x0), .Y(y0), .colour(c0), .plot(plot0), .busy(busy0), .done(done0)
    );

    draw_board_region #(.RAM_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .row_lo(row_lo), .row_hi(row_hi),
        .outline_en(outline_en), .outline_colour(outline_colour), .ram_addr(ram_addr1),
        .ram_Q(ram_q1), .X(x1), .Y(y1), .colour(c1), .plot(plot1), .busy(busy1), .done(done1)
    );

    // Board RAM contents: mode 0 returns addr[5:0]; mode 1 alternates 6'h30 / empty.
    int ram_mode = 0;
    function automatic logic [5:0] ram_colour(input int addr);
        if (ram_mode == 0) return addr[5:0];
        return (addr % 2 == 0) ? 6'h30 : 6'h00;
    endfunction

    logic [5:0] q0_pipe;
    logic [5:0] q1_pipe [3];
    always @(posedge clk) begin
        q0_pipe    <= ram_colour(int'(ram_addr0));
        q1_pipe[0] <= ram_colour(int'(ram_addr1));
        q1_pipe[1] <= q1_pipe[0];
        q1_pipe[2] <= q1_pipe[1];
    end
    assign ram_q0 = q0_pipe;
    assign ram_q1 = q1_pipe[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [20:0] exp_q0[$];
    logic [20:0] exp_q1[$];
    int compared = 0;
    int failed = 0;
    int n_plot[2], n_done[2], first_c[2], last_c[2], done_c[2];
    int min_x[2], max_x[2], min_y[2], max_y[2], min_a[2], max_a[2];
    int cnt_3f[2], cnt_30[2], cnt_00[2];
    logic [20:0] first_px[2], last_px[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            n_plot[d] = 0; n_done[d] = 0; first_c[d] = -1; last_c[d] = -1; done_c[d] = -1;
            min_x[d] = 255; max_x[d] = 0; min_y[d] = 127; max_y[d] = 0;
            min_a[d] = 255; max_a[d] = 0;
            cnt_3f[d] = 0; cnt_30[d] = 0; cnt_00[d] = 0;
        end
    endtask

    task automatic note_plot(input int d, input logic [20:0] px);
        int x, y;
        x = int'(px[20:13]);
        y = int'(px[12:6]);
        n_plot[d]++;
        if (first_c[d] < 0) begin
            first_c[d] = cyc;
            first_px[d] = px;
        end
        last_c[d] = cyc;
        last_px[d] = px;
        if (x < min_x[d]) min_x[d] = x;
        if (x > max_x[d]) max_x[d] = x;
        if (y < min_y[d]) min_y[d] = y;
        if (y > max_y[d]) max_y[d] = y;
        if (px[5:0] == 6'h3F) cnt_3f[d]++;
        if (px[5:0] == 6'h30) cnt_30[d]++;
        if (px[5:0] == 6'h00) cnt_00[d]++;
    endtask

    task automatic note_addr(input int d, input logic [7:0] a);
        if (int'(a) < min_a[d]) min_a[d] = int'(a);
        if (int'(a) > max_a[d]) max_a[d] = int'(a);
    endtask

    // Single compare process for both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (plot0) begin
                if (exp_q0.size() == 0) begin
                    compared++; failed++;
                    $display("FAIL extra_plot0: actual plot with X=%0d Y=%0d required no plot", x0, y0);
                end else check("pixel0", 32'({x0, y0, c0}), 32'(exp_q0.pop_front()));
                note_plot(0, {x0, y0, c0});
            end
            if (plot1) begin
                if (exp_q1.size() == 0) begin
                    compared++; failed++;
                    $display("FAIL extra_plot1: actual plot with X=%0d Y=%0d required no plot", x1, y1);
                end else check("pixel1", 32'({x1, y1, c1}), 32'(exp_q1.pop_front()));
                note_plot(1, {x1, y1, c1});
            end
            if (done0) begin n_done[0]++; done_c[0] = cyc; end
            if (done1) begin n_done[1]++; done_c[1] = cyc; end
            if (busy0) note_addr(0, ram_addr0);
            if (busy1) note_addr(1, ram_addr1);
        end
    end

    // Behavioural model: list every pixel of the clamped band in scan order.
    task automatic model(input int d, input int lo, input int hi, input logic oen, input logic [5:0] oc);
        int top;
        logic [5:0] q, c;
        logic [20:0] px;
        bit border;
        top = (hi > BH - 1) ? BH - 1 : hi;
        for (int r = lo; r <= top; r++)
            for (int col = 0; col < BW; col++)
                for (int oy = 0; oy < CP; oy++)
                    for (int ox = 0; ox < CP; ox++) begin
                        q = ram_colour(r * BW + col);
                        border = (ox == 0) || (oy == 0) || (ox == CP - 1) || (oy == CP - 1);
                        c = (oen && q != 6'h00 && border) ? oc : q;
                        px = {8'(XO + col * CP + ox), 7'(YO + r * CP + oy), c};
                        if (d == 0) exp_q0.push_back(px);
                        else exp_q1.push_back(px);
                    end
    endtask

    task automatic launch(input int d, input int lo, input int hi, input logic oen,
                          input logic [5:0] oc, output int c_start);
        clear_stats();
        model(d, lo, hi, oen, oc);
        @(posedge clk); #1;
        row_lo = 6'(lo); row_hi = 6'(hi); outline_en = oen; outline_colour = oc;
        if (d == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk); #1;
        c_start = cyc;
        start0 = 1'b0; start1 = 1'b0;
        // Inputs change freely once the run is accepted.
        row_lo = 6'd63; row_hi = 6'd0; outline_en = ~oen; outline_colour = ~oc;
        check("busy_rise", 32'((d == 0) ? busy0 : busy1), 32'd1);
    endtask

    task automatic wait_done(input int d, input int budget, input bit hammer);
        int n = 0;
        while (n_done[d] == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (hammer) start1 = 1'b1;
        end
        start1 = 1'b0;
        if (n_done[d] == 0) begin
            compared++; failed++;
            $display("FAIL timeout_done%0d: actual no done in %0d cycles required done", d, budget);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic finish_run(input int d, input int c_start, input int exp_plots, input int lat);
        check("plot_count", 32'(n_plot[d]), 32'(exp_plots));
        check("leftover", 32'((d == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
        check("done_count", 32'(n_done[d]), 32'd1);
        if (exp_plots > 0) begin
            check("first_latency", 32'(first_c[d] - c_start), 32'(lat + 1));
            check("contiguous", 32'(last_c[d] - first_c[d] + 1), 32'(exp_plots));
            check("done_after_last", 32'(done_c[d] - last_c[d]), 32'd1);
        end else begin
            check("done_latency", 32'(done_c[d] - c_start), 32'd1);
        end
        check("busy_fall", 32'((d == 0) ? busy0 : busy1), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs, n;
        start0 = 0; start1 = 0; row_lo = 0; row_hi = 0; outline_en = 0; outline_colour = 0;
        clear_stats();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_X", 32'(x0), 32'd0);
        check("rst_Y", 32'(y0), 32'd0);
        check("rst_colour", 32'(c0), 32'd0);
        check("rst_plot", 32'(plot0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_addr", 32'(ram_addr0), 32'd0);
        check("rst_plot_l3", 32'(plot1), 32'd0);
        reset = 1'b0;

        // Full redraw
        launch(0, 0, 24, 1'b0, 6'h00, cs);
        wait_done(0, 6000, 1'b0);
        finish_run(0, cs, 4000, 1);
        check("full_first_px", 32'(first_px[0]), 32'({8'd59, 7'd11, 6'h00}));
        check("full_last_px", 32'(last_px[0]), 32'({8'd98, 7'd110, 6'h39}));

        // Single row
        launch(0, 3, 3, 1'b0, 6'h00, cs);
        wait_done(0, 1000, 1'b0);
        finish_run(0, cs, 160, 1);
        check("row3_min_y", 32'(min_y[0]), 32'd23);
        check("row3_max_y", 32'(max_y[0]), 32'd26);
        check("row3_min_x", 32'(min_x[0]), 32'd59);
        check("row3_max_x", 32'(max_x[0]), 32'd98);
        check("row3_min_addr", 32'(min_a[0]), 32'd30);
        check("row3_max_addr", 32'(max_a[0]), 32'd39);

        // Inverted range: nothing drawn
        launch(0, 5, 2, 1'b0, 6'h00, cs);
        wait_done(0, 100, 1'b0);
        finish_run(0, cs, 0, 1);

        // row_hi beyond the board is clamped to the last row
        launch(0, 20, 40, 1'b0, 6'h00, cs);
        wait_done(0, 2000, 1'b0);
        finish_run(0, cs, 800, 1);

        // Outline mode on alternating full/empty cells
        ram_mode = 1;
        launch(0, 0, 0, 1'b1, 6'h3F, cs);
        wait_done(0, 1000, 1'b0);
        finish_run(0, cs, 160, 1);
        check("outline_border", 32'(cnt_3f[0]), 32'd60);
        check("outline_inner", 32'(cnt_30[0]), 32'd20);
        check("outline_empty", 32'(cnt_00[0]), 32'd80);
        ram_mode = 0;

        // Reset in the middle of a run
        launch(0, 0, 24, 1'b0, 6'h00, cs);
        n = 0;
        while (n_plot[0] < 100 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrun_reached", 32'(n_plot[0] >= 100), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrun_rst_plot", 32'(plot0), 32'd0);
        check("midrun_rst_busy", 32'(busy0), 32'd0);
        check("midrun_rst_done", 32'(done0), 32'd0);
        reset = 1'b0;
        exp_q0.delete();
        clear_stats();
        repeat (20) @(posedge clk);
        #1;
        check("midrun_no_plot", 32'(n_plot[0]), 32'd0);
        check("midrun_no_done", 32'(n_done[0]), 32'd0);
        launch(0, 10, 12, 1'b0, 6'h00, cs);
        wait_done(0, 2000, 1'b0);
        finish_run(0, cs, 480, 1);

        // Latency-3 build with start held high throughout, including the done cycle
        launch(1, 0, 1, 1'b0, 6'h00, cs);
        wait_done(1, 2000, 1'b1);
        finish_run(1, cs, 320, 3);
        check("l3_first_px", 32'(first_px[1]), 32'({8'd59, 7'd11, 6'h00}));
        check("l3_last_px", 32'(last_px[1]), 32'({8'd98, 7'd18, 6'h13}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
